// File: rtl/mult4s_pkg.sv
// rtl/mult4s_pkg.sv - shared constants, state codes and counter sizing for the shift-add multiplier
package mult4s_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-counter width; a one-bit multiplier still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult4s_shift_add.sv
// rtl/mult4s_shift_add.sv - operand registers, accumulator and bit counter for shift-add multiply
module mult4s_shift_add
    import mult4s_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 ck,
    input  logic                 res,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   sum
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] addend;

    // Partial product for the current bit and the running sum including it.
    always_comb begin
        addend = '0;
        if (b_reg[cnt]) begin
            addend = {{WIDTH{1'b0}}, a_reg} << cnt;
        end
        sum = acc + addend;
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // Load captures operands and clears state; step folds in one partial product.
    always_ff @(posedge ck) begin
        if (res) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= sum;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mult4s_1.sv
// rtl/mult4s_1.sv - sequential unsigned multiplier top: FSM, done pulse, product register (option MULT4S_RESTART_EN)
module mult4s_1
    import mult4s_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 ck,
    input  logic                 res,
    input  logic                 start,
    output logic                 done,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p
);

`ifdef MULT4S_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic [1:0]         state;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] sum;

    // A start is accepted outside CALC, or inside CALC only when restart is built in.
    assign load = start && ((state != ST_CALC) || RESTART);
    assign step = (state == ST_CALC) && !load;

    mult4s_shift_add #(
        .WIDTH (WIDTH)
    ) u_dp (
        .ck    (ck),
        .res   (res),
        .load  (load),
        .step  (step),
        .a     (a),
        .b     (b),
        .last  (last),
        .sum   (sum)
    );

    // Sequencing: the product is published only on the final iteration.
    always_ff @(posedge ck) begin
        if (res) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (load) begin
                        state <= ST_CALC;
                    end else if (last) begin
                        p     <= sum;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= load ? ST_CALC : ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult4s_1.sv
// tb/tb_mult4s_1.sv - self-checking bench for mult4s_1 (honours MULT4S_RESTART_EN)
module tb_mult4s_1;

    localparam int W = 4;

    logic           ck = 1'b0;
    logic           res;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           done;
    logic [2*W-1:0] p;

    int total = 0;
    int bad   = 0;

    always #5 ck = ~ck;

    mult4s_1 #(.WIDTH(W)) dut (
        .ck    (ck),
        .res   (res),
        .start (start),
        .done  (done),
        .a     (a),
        .b     (b),
        .p     (p)
    );

    function automatic int model(input int x, input int y);
        return x * y;
    endfunction

    // One-cycle start pulse; returns at the falling edge after the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge ck);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
    endtask

    // Cycles until done is seen, or -1 when the budget runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge ck);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int highs;
        res = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        @(negedge ck);
        @(negedge ck);
        res = 1'b0;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++;
        if (p !== '0) begin bad++; $display("FAIL reset_p got=%0d want=0", p); end
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ck);
            if (done === 1'b1) highs++;
        end
        total++;
        if (highs != 0) begin bad++; $display("FAIL reset_idle_done got=%0d want=0", highs); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h1, 4'h8, 4'hF};
        logic [W-1:0] tb [7] = '{4'h0, 4'h1, 4'h8, 4'hF, 4'hA, 4'hA, 4'hA};
        int lat;
        int exp;
        int moved;
        for (int k = 0; k < 7; k++) begin
            exp = model(int'(ta[k]), int'(tb[k]));
            launch(ta[k], tb[k]);
            wait_done(lat);
            total++;
            if (lat != W) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", k, lat, W); end
            total++;
            if (p !== (2*W)'(exp)) begin bad++; $display("FAIL dir_p[%0d] got=%0d want=%0d", k, p, exp); end
            @(negedge ck);
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL dir_pulse_width[%0d] got=%0b want=0", k, done); end
            moved = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge ck);
                if (p !== (2*W)'(exp) || done !== 1'b0) moved++;
            end
            total++;
            if (moved != 0) begin bad++; $display("FAIL dir_hold[%0d] got=%0d want=0", k, moved); end
        end
    endtask

    task automatic test_random();
        int lat;
        int x;
        int y;
        for (int k = 0; k < 16; k++) begin
            x = $urandom_range(0, (1 << W) - 1);
            y = $urandom_range(0, (1 << W) - 1);
            launch(W'(x), W'(y));
            wait_done(lat);
            total++;
            if (lat != W || p !== (2*W)'(model(x, y))) begin
                bad++;
                $display("FAIL rand[%0d] %0d*%0d got=%0d lat=%0d want=%0d lat=%0d", k, x, y, p, lat, model(x, y), W);
            end
            @(negedge ck);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        launch(4'hF, 4'hA);
        @(negedge ck);
        @(negedge ck);
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
        wait_done(lat);
        total++;
        if (lat != W - 2) begin bad++; $display("FAIL opchg_latency got=%0d want=%0d", lat, W - 2); end
        total++;
        if (p !== 8'd150) begin bad++; $display("FAIL opchg_p got=%0d want=150", p); end
        @(negedge ck);
    endtask

    task automatic test_start_in_calc();
        int pulses;
        int first;
        int pdone;
        int exp_cyc;
        int exp_p;
`ifdef MULT4S_RESTART_EN
        exp_cyc = 3 + W;
        exp_p   = model(3, 2);
`else
        exp_cyc = W;
        exp_p   = model(7, 9);
`endif
        launch(4'h7, 4'h9);
        @(negedge ck);
        @(negedge ck);
        a = 4'h3;
        b = 4'h2;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        pulses = 0;
        first = -1;
        pdone = -1;
        for (int c = 4; c <= 16; c++) begin
            @(negedge ck);
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    pdone = int'(p);
                end
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL calc_start_pulses got=%0d want=1", pulses); end
        total++;
        if (first != exp_cyc) begin bad++; $display("FAIL calc_start_cycle got=%0d want=%0d", first, exp_cyc); end
        total++;
        if (pdone != exp_p) begin bad++; $display("FAIL calc_start_p got=%0d want=%0d", pdone, exp_p); end
    endtask

    task automatic test_midop_reset();
        int lat;
        int pulses;
        launch(4'h5, 4'h5);
        wait_done(lat);
        total++;
        if (p !== 8'd25) begin bad++; $display("FAIL mid_pre_p got=%0d want=25", p); end
        @(negedge ck);
        launch(4'hF, 4'hF);
        @(negedge ck);
        res = 1'b1;
        @(negedge ck);
        res = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ck);
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", pulses); end
        total++;
        if (p !== '0) begin bad++; $display("FAIL mid_p_cleared got=%0d want=0", p); end
        launch(4'h3, 4'h5);
        wait_done(lat);
        total++;
        if (lat != W || p !== 8'd15) begin bad++; $display("FAIL mid_next got=%0d lat=%0d want=15 lat=%0d", p, lat, W); end
        @(negedge ck);
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(4'h2, 4'h3);
        wait_done(lat);
        total++;
        if (p !== 8'd6) begin bad++; $display("FAIL b2b_first got=%0d want=6", p); end
        a = 4'h4;
        b = 4'h5;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%0b want=0", done); end
        wait_done(lat);
        total++;
        if (lat != W || p !== 8'd20) begin bad++; $display("FAIL b2b_second got=%0d lat=%0d want=20 lat=%0d", p, lat, W); end
        @(negedge ck);
    endtask

    initial begin
        res = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_random();
        test_operand_change();
        test_start_in_calc();
        test_midop_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
